// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx -- parallel-in / serial-out frame transmitter.
//
// A word accepted on the load_valid/load_ready handshake is sent as a frame:
// one START cycle (line high), WIDTH data bits, an optional even-parity bit,
// and one STOP cycle (line low, done pulses). A new word may be accepted in
// the STOP cycle, giving back-to-back frames with no idle gap.
//
// Optional feature: define PISO_TX_PARITY_EN to insert a PARITY cycle that
// carries the XOR of all data bits (frame is low during it).
//
// Parameters:
//   WIDTH      data word width in bits (>= 2)
//   MSB_FIRST  0: bit 0 sent first, 1: bit WIDTH-1 sent first
//
// Ports:
//   clk         rising-edge clock, one serial bit per cycle
//   rst         asynchronous active-high reset
//   data_in     parallel word, sampled only on an accept
//   load_valid  data_in holds a word to send
//   load_ready  block can take a word this cycle (IDLE or STOP)
//   serial_out  serial line, idle level 0 (registered)
//   frame       high while serial_out carries a data bit (registered)
//   busy        high in any state other than IDLE (registered)
//   done        one-cycle pulse in the STOP cycle of each frame (registered)
// -----------------------------------------------------------------------------
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef PISO_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             head_bit;
    logic [WIDTH-1:0] shreg_next;
`ifdef PISO_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign load_ready = (state == S_IDLE) || (state == S_STOP);
    assign accept     = load_valid && load_ready;

    // The bit to put on the line next always sits at the "head" end of the
    // shift register; shifting moves the following bit into that position.
    always_comb begin
        head_bit   = 1'b0;
        shreg_next = '0;
        if (MSB_FIRST) begin
            head_bit   = shreg[WIDTH-1];
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            head_bit   = shreg[0];
            shreg_next = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // Outputs are registered from the next-state decision so that each
    // output is valid in the same cycle as the state it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            serial_out <= 1'b0;
            frame      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_STOP: begin
                    if (accept) begin
                        state      <= S_START;
                        shreg      <= data_in;
`ifdef PISO_TX_PARITY_EN
                        parity_bit <= ^data_in;
`endif
                        serial_out <= 1'b1;
                        frame      <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        state      <= S_IDLE;
                        serial_out <= 1'b0;
                        frame      <= 1'b0;
                        busy       <= 1'b0;
                    end
                end

                S_START: begin
                    state      <= S_DATA;
                    bit_cnt    <= '0;
                    serial_out <= head_bit;
                    shreg      <= shreg_next;
                    frame      <= 1'b1;
                    busy       <= 1'b1;
                end

                S_DATA: begin
                    busy <= 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        frame   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
                        state      <= S_PARITY;
                        serial_out <= parity_bit;
`else
                        state      <= S_STOP;
                        serial_out <= 1'b0;
                        done       <= 1'b1;
`endif
                    end else begin
                        bit_cnt    <= bit_cnt + CNT_W'(1);
                        serial_out <= head_bit;
                        shreg      <= shreg_next;
                        frame      <= 1'b1;
                    end
                end

`ifdef PISO_TX_PARITY_EN
                S_PARITY: begin
                    state      <= S_STOP;
                    serial_out <= 1'b0;
                    frame      <= 1'b0;
                    busy       <= 1'b1;
                    done       <= 1'b1;
                end
`endif

                default: begin
                    state      <= S_IDLE;
                    bit_cnt    <= '0;
                    serial_out <= 1'b0;
                    frame      <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
